fwd_hazard_unit: RTL and testbench

- Registered forwarding-select and load-use hazard controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Tracks destination registers of instructions it has issued into EX and MEM.
- Each cycle it compares the ID-stage instruction's sources against those entries and latches the 2-bit operand selects that drive the EX-stage 3:1 operand muxes. Select encoding: 00 register file, 01 MEM/WB result, 10 EX/MEM result, 11 zero.
- Raises a load-use stall and keeps a saturating stall counter.

---
 rtl/fwd_hazard_unit.sv | 134 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//
// Forwarding-select and load-use hazard controller for a 5-stage RV32I
// pipeline (IF/ID/EX/MEM/WB). The unit keeps a shadow copy of the
// destination info of the instructions it has issued into EX and MEM.
// Each cycle it compares the ID instruction's sources against those
// shadows. It then registers the operand selects used by the EX-stage
// 3:1 operand muxes.
//
// Select encoding: 00 register file, 01 MEM/WB result, 10 EX/MEM result,
// 11 zero (source is x0).
//
// Ports
//   clk_i, rst_n_i       clock (rising edge), asynchronous active-low reset
//   id_valid_i           ID holds a real instruction
//   id_rs1_i, id_rs2_i   ID source registers
//   id_use_rs1_i/rs2_i   the ID instruction actually reads rs1 / rs2
//   id_rd_i              ID destination register
//   id_regwrite_i        ID instruction writes rd
//   id_memread_i         ID instruction is a load
//   flush_i              squash the ID instruction
//   hold_i               global pipeline freeze
//   fwd_a_sel_o          rs1 operand select for the instruction in EX
//   fwd_b_sel_o          rs2 operand select for the instruction in EX
//   stall_o              load-use stall (combinational)
//   stall_cnt_o          saturating count of stall cycles
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Shadow entries for the instructions currently in EX and MEM.
    logic              ex_valid, ex_regwrite, ex_memread;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_valid, mem_regwrite, mem_memread;
    logic [REG_AW-1:0] mem_rd;

    logic       ex_writer, mem_writer;
    logic [1:0] sel_a_next, sel_b_next;

    // Writes to x0 are discarded by the register file, so they never forward.
    assign ex_writer  = ex_valid  & ex_regwrite  & (ex_rd  != '0);
    assign mem_writer = mem_valid & mem_regwrite & (mem_rd != '0);

    // A load sitting in EX has no data yet for a dependent instruction in ID.
    // A flushed ID instruction is about to be discarded, so it never stalls.
    assign stall_o = id_valid_i & ~flush_i & ex_valid & ex_memread & (ex_rd != '0)
                   & ((id_use_rs1_i & (id_rs1_i == ex_rd))
                   |  (id_use_rs2_i & (id_rs2_i == ex_rd)));

    // Nearest producer wins. The EX entry is the younger writer, so it is
    // checked before the MEM entry.
    function automatic logic [1:0] sel_for(
        input logic [REG_AW-1:0] rs,
        input logic              exw,
        input logic [REG_AW-1:0] exrd,
        input logic              memw,
        input logic [REG_AW-1:0] memrd
    );
        if (rs == '0)                 return 2'b11;
        else if (exw && rs == exrd)   return 2'b10;
        else if (memw && rs == memrd) return 2'b01;
        else                          return 2'b00;
    endfunction

    always_comb begin
        sel_a_next = sel_for(id_rs1_i, ex_writer, ex_rd, mem_writer, mem_rd);
        sel_b_next = sel_for(id_rs2_i, ex_writer, ex_rd, mem_writer, mem_rd);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            fwd_a_sel_o  <= 2'b00;
            fwd_b_sel_o  <= 2'b00;
            stall_cnt_o  <= '0;
        end else if (hold_i) begin
            // Frozen pipeline: every register keeps its value.
        end else begin
            // EX always advances into MEM unless the pipeline is held.
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            if (flush_i || stall_o) begin
                // A bubble enters EX. Its selects are irrelevant, so they are parked at 00.
                ex_valid    <= 1'b0;
                ex_rd       <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                fwd_a_sel_o <= 2'b00;
                fwd_b_sel_o <= 2'b00;
                // stall_o is already low during a flush, so only true stalls count.
                if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
                    stall_cnt_o <= stall_cnt_o + 1'b1;
                end
            end else begin
                // An invalid ID slot becomes a bubble. Its selects still latch,
                // but nothing downstream uses them.
                ex_valid    <= id_valid_i;
                ex_rd       <= id_rd_i;
                ex_regwrite <= id_regwrite_i;
                ex_memread  <= id_memread_i;
                fwd_a_sel_o <= sel_a_next;
                fwd_b_sel_o <= sel_b_next;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       id_valid_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic       id_use_rs1_i, id_use_rs2_i;
    logic       id_regwrite_i, id_memread_i;
    logic       flush_i, hold_i;
    logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
    logic       stall_o;
    logic [15:0] stall_cnt_o;

    // Second instance with a narrow counter, used for the saturation check.
    logic [1:0] sat_a_sel, sat_b_sel;
    logic       sat_stall;
    logic [2:0] sat_cnt;

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .id_valid_i(id_valid_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(3)) dut_sat (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .id_valid_i(id_valid_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .fwd_a_sel_o(sat_a_sel), .fwd_b_sel_o(sat_b_sel),
        .stall_o(sat_stall), .stall_cnt_o(sat_cnt)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u1, input logic u2, input logic [4:0] rd,
                           input logic rw, input logic mr);
        id_valid_i    = 1'b1;
        id_rs1_i      = rs1;
        id_rs2_i      = rs2;
        id_use_rs1_i  = u1;
        id_use_rs2_i  = u2;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr);
        present(rs1, rs2, 1'b1, 1'b1, rd, rw, mr);
        tick();
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
        id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;
        id_regwrite_i = 1'b0; id_memread_i = 1'b0;
        flush_i = 1'b0; hold_i = 1'b0;

        // Reset state
        #3;
        chk("reset_a", fwd_a_sel_o, 2'b00);
        chk("reset_b", fwd_b_sel_o, 2'b00);
        chk("reset_stall", stall_o, 1'b0);
        chk("reset_cnt", stall_cnt_o, 16'd0);
        tick();
        tick();
        rst_n_i = 1'b1;

        // Back-to-back dependency: add x5 then sub x5, x6
        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        present(5'd5, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        chk("b2b_stall", stall_o, 1'b0);
        tick();
        chk("b2b_a", fwd_a_sel_o, 2'b10);
        chk("b2b_b", fwd_b_sel_o, 2'b00);

        // Two writers of x7: nearest one (EX) wins
        issue(5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        issue(5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        issue(5'd7, 5'd7, 5'd13, 1'b1, 1'b0);
        chk("prio_a", fwd_a_sel_o, 2'b10);
        chk("prio_b", fwd_b_sel_o, 2'b10);

        // Distance 2: writer x7, unrelated x12, then consumer of x7
        issue(5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        issue(5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
        issue(5'd7, 5'd3, 5'd14, 1'b1, 1'b0);
        chk("dist2_a", fwd_a_sel_o, 2'b01);
        chk("dist2_b", fwd_b_sel_o, 2'b00);

        // Writer to x0 then consumer of x0 (rs2 = x14, now in MEM)
        issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        present(5'd0, 5'd14, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("x0_stall", stall_o, 1'b0);
        tick();
        chk("x0_a", fwd_a_sel_o, 2'b11);
        chk("x0_b", fwd_b_sel_o, 2'b01);

        // Load to x0 followed by a use of x0 must not stall
        issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
        present(5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("ldx0_stall", stall_o, 1'b0);
        tick();
        chk("ldx0_cnt", stall_cnt_o, 16'd0);

        // Load-use: lw x9 then add x15, x4, x9
        issue(5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
        present(5'd4, 5'd9, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
        chk("lu_stall", stall_o, 1'b1);
        tick();
        chk("lu_bubble_a", fwd_a_sel_o, 2'b00);
        chk("lu_bubble_b", fwd_b_sel_o, 2'b00);
        chk("lu_cnt1", stall_cnt_o, 16'd1);
        chk("lu_no_second_stall", stall_o, 1'b0);
        tick();
        chk("lu_fwd_a", fwd_a_sel_o, 2'b00);
        chk("lu_fwd_b", fwd_b_sel_o, 2'b01);
        chk("lu_cnt_after", stall_cnt_o, 16'd1);

        // Flush during a load-use condition
        issue(5'd15, 5'd2, 5'd9, 1'b1, 1'b1);
        chk("pre_flush_a", fwd_a_sel_o, 2'b10);
        present(5'd4, 5'd9, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
        flush_i = 1'b1;
        #1;
        chk("flush_stall", stall_o, 1'b0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("flush_a", fwd_a_sel_o, 2'b00);
        chk("flush_b", fwd_b_sel_o, 2'b00);
        chk("flush_cnt", stall_cnt_o, 16'd1);
        chk("flush_ex_bubble", stall_o, 1'b0);
        tick();
        chk("flush_fwd_b", fwd_b_sel_o, 2'b01);

        // Hold for 3 cycles during a stall
        issue(5'd15, 5'd2, 5'd9, 1'b1, 1'b1);
        present(5'd9, 5'd3, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0);
        chk("hold_pre_stall", stall_o, 1'b1);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_stall", stall_o, 1'b1);
            chk("hold_a", fwd_a_sel_o, 2'b10);
            chk("hold_b", fwd_b_sel_o, 2'b00);
            chk("hold_cnt", stall_cnt_o, 16'd1);
        end
        hold_i = 1'b0;
        #1;
        chk("unhold_stall", stall_o, 1'b1);
        tick();
        chk("unhold_cnt", stall_cnt_o, 16'd2);
        chk("unhold_a", fwd_a_sel_o, 2'b00);
        chk("unhold_clear", stall_o, 1'b0);
        tick();
        chk("unhold_fwd_a", fwd_a_sel_o, 2'b01);

        // Saturation: 8 more stalls; the 3-bit counter must stop at 7
        for (int i = 0; i < 8; i++) begin
            issue(5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
            present(5'd3, 5'd9, 1'b0, 1'b1, 5'd17, 1'b1, 1'b0);
            tick();
        end
        chk("sat_cnt_wide", stall_cnt_o, 16'd10);
        chk("sat_cnt_narrow", sat_cnt, 3'd7);

        // Asynchronous reset in the middle of a stall
        issue(5'd9, 5'd2, 5'd9, 1'b1, 1'b1);
        chk("pre_rst_a", fwd_a_sel_o, 2'b01);
        present(5'd3, 5'd9, 1'b1, 1'b1, 5'd18, 1'b1, 1'b0);
        chk("pre_rst_stall", stall_o, 1'b1);
        rst_n_i = 1'b0;
        #1;
        chk("midrst_a", fwd_a_sel_o, 2'b00);
        chk("midrst_b", fwd_b_sel_o, 2'b00);
        chk("midrst_stall", stall_o, 1'b0);
        chk("midrst_cnt", stall_cnt_o, 16'd0);
        chk("midrst_cnt_narrow", sat_cnt, 3'd0);
        tick();
        rst_n_i = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
